// File: rtl/serial_fa_ctrl.sv
// Bit-serial adder: one gate-level full adder reused for WIDTH cycles, LSB first,
// wrapped in an IDLE/RUN/DONE controller with a start/done handshake.

module _xor2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a ^ b;
endmodule

module _and2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module _or2 (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a | b;
endmodule

// One-bit full adder built only from the two-input primitives.
module serial_fa_bit (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    logic p;
    logic g;
    logic t;

    _xor2 u_xor_p   (.a(a), .b(b), .y(p));
    _xor2 u_xor_sum (.a(p), .b(c), .y(sum));
    _and2 u_and_g   (.a(a), .b(b), .y(g));
    _and2 u_and_t   (.a(c), .b(p), .y(t));
    _or2  u_or_cy   (.a(g), .b(t), .y(carry));
endmodule

module serial_fa_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,  state_d;
    logic [WIDTH-1:0]   op_a_q,   op_a_d;
    logic [WIDTH-1:0]   op_b_q,   op_b_d;
    logic [WIDTH-1:0]   res_q,    res_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;

    logic fa_sum;
    logic fa_carry;

    serial_fa_bit u_fa (
        .a     (op_a_q[0]),
        .b     (op_b_q[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case can infer a latch.
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            IDLE, DONE: begin
                // DONE with start is an implicit acknowledge; otherwise DONE lasts one cycle.
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                carry_d = fa_carry;
                cnt_d   = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    // carry_q here is the carry into the MSB.
                    cout_d  = fa_carry;
                    ovf_d   = carry_q ^ fa_carry;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign s    = res_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_fa_ctrl.sv
// Bench for serial_fa_ctrl at WIDTH=8 and WIDTH=4: cycle model plus directed literals.

module tb_serial_fa_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start8, cin8, busy8, done8, cout8, ovf8;
    logic [7:0] a8, b8, s8;
    logic       start4, cin4, busy4, done4, cout4, ovf4;
    logic [3:0] a4, b4, s4;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    serial_fa_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8)
    );

    serial_fa_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {ovf, cout, sum} of a w-bit add using plain integer arithmetic.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] x,
                                            input logic [31:0] y, input logic ci);
        logic [32:0] mask;
        logic [32:0] sum;
        logic [31:0] sv;
        logic        co;
        logic        v;
        mask = (33'd1 << w) - 33'd1;
        sum  = {1'b0, x} + {1'b0, y} + {32'd0, ci};
        sv   = sum[31:0] & mask[31:0];
        co   = sum[w];
        v    = (x[w-1] == y[w-1]) && (sv[w-1] != x[w-1]);
        return {v, co, sv};
    endfunction

    // Model: counts down WIDTH busy cycles after an accepted start, then one done cycle.
    int          m8_left, m4_left;
    logic        m8_done, m4_done, m8_c, m4_c, m8_v, m4_v;
    logic [31:0] m8_s, m4_s;
    logic [33:0] m8_p, m4_p;

    always @(posedge clk) begin
        if (reset) begin
            m8_left = 0; m8_done = 1'b0; m8_s = '0; m8_c = 1'b0; m8_v = 1'b0;
        end else if (m8_left > 0) begin
            m8_left--;
            if (m8_left == 0) begin
                m8_done = 1'b1;
                {m8_v, m8_c, m8_s} = m8_p;
            end
        end else if (start8) begin
            m8_p    = ref_add(8, {24'd0, a8}, {24'd0, b8}, cin8);
            m8_left = 8;
            m8_done = 1'b0;
        end else begin
            m8_done = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m4_left = 0; m4_done = 1'b0; m4_s = '0; m4_c = 1'b0; m4_v = 1'b0;
        end else if (m4_left > 0) begin
            m4_left--;
            if (m4_left == 0) begin
                m4_done = 1'b1;
                {m4_v, m4_c, m4_s} = m4_p;
            end
        end else if (start4) begin
            m4_p    = ref_add(4, {28'd0, a4}, {28'd0, b4}, cin4);
            m4_left = 4;
            m4_done = 1'b0;
        end else begin
            m4_done = 1'b0;
        end
    end

    // Compare process: results are only meaningful outside RUN.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc busy8", busy8, m8_left > 0);
            check("cyc done8", done8, m8_done);
            if (m8_left == 0) begin
                check("cyc s8", s8, m8_s);
                check("cyc cout8", cout8, m8_c);
                check("cyc ovf8", ovf8, m8_v);
            end
            check("cyc busy4", busy4, m4_left > 0);
            check("cyc done4", done4, m4_done);
            if (m4_left == 0) begin
                check("cyc s4", s4, m4_s);
                check("cyc cout4", cout4, m4_c);
                check("cyc ovf4", ovf4, m4_v);
            end
        end
    end

    task automatic go8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        @(negedge clk);
        a8 = x; b8 = y; cin8 = ci; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic go4(input logic [3:0] x, input logic [3:0] y, input logic ci);
        @(negedge clk);
        a4 = x; b4 = y; cin4 = ci; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
    endtask

    task automatic wait_done8(output int busy_cycles);
        busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (done8) break;
            if (busy8) busy_cycles++;
            @(negedge clk);
        end
        check("done8 within budget", done8, 1'b1);
    endtask

    task automatic wait_done4(output int busy_cycles);
        busy_cycles = 0;
        for (int k = 0; k < 40; k++) begin
            if (done4) break;
            if (busy4) busy_cycles++;
            @(negedge clk);
        end
        check("done4 within budget", done4, 1'b1);
    endtask

    task automatic run8(input string name, input logic [7:0] x, input logic [7:0] y,
                        input logic ci, input logic [7:0] es, input logic ec, input logic ev);
        int nb;
        go8(x, y, ci);
        wait_done8(nb);
        check({name, " busy cycles"}, nb, 8);
        check({name, " s"}, s8, es);
        check({name, " cout"}, cout8, ec);
        check({name, " ovf"}, ovf8, ev);
        @(negedge clk);
        check({name, " done one cycle"}, done8, 1'b0);
        check({name, " back to idle"}, busy8, 1'b0);
    endtask

    initial begin
        int nb;
        reset = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("idle busy", busy8, 1'b0);
        check("idle done", done8, 1'b0);
        check("idle s", s8, 8'h00);
        check("idle cout/ovf", {cout8, ovf8}, 2'b00);

        run8("3C+25", 8'h3C, 8'h25, 1'b0, 8'h61, 1'b0, 1'b0);
        run8("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("80+80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Operands change one cycle after start; captured values must be used.
        go8(8'hFF, 8'hFF, 1'b1);
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        wait_done8(nb);
        check("FF+FF+1 s", s8, 8'hFF);
        check("FF+FF+1 cout/ovf", {cout8, ovf8}, 2'b10);

        // start pulsed again mid-RUN is ignored.
        go8(8'h12, 8'h34, 1'b0);
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(nb);
        check("repulse s", s8, 8'h46);
        @(negedge clk);

        // Reset sampled on the edge ending the 4th RUN cycle.
        go8(8'h55, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        check("pre-reset busy", busy8, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid reset busy", busy8, 1'b0);
        check("mid reset done", done8, 1'b0);
        check("mid reset s", s8, 8'h00);
        run8("10+20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);

        // start held during DONE: implicit acknowledge, back-to-back operation.
        go8(8'h40, 8'h40, 1'b0);
        wait_done8(nb);
        check("b2b first s", s8, 8'h80);
        check("b2b first ovf", ovf8, 1'b1);
        a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        check("b2b done dropped", done8, 1'b0);
        check("b2b busy rose", busy8, 1'b1);
        wait_done8(nb);
        check("b2b busy cycles", nb, 8);
        check("b2b second s", s8, 8'h03);
        @(negedge clk);
        check("b2b done one cycle", done8, 1'b0);

        // WIDTH=4 instance.
        go4(4'hF, 4'h1, 1'b0);
        wait_done4(nb);
        check("w4 busy cycles", nb, 4);
        check("w4 s", s4, 4'h0);
        check("w4 cout", cout4, 1'b1);
        check("w4 ovf", ovf4, 1'b0);
        @(negedge clk);
        check("w4 done one cycle", done4, 1'b0);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_fa_ctrl.md
Name: serial_fa_ctrl

Overview:
Bit-serial adder controller. A single gate-level 1-bit full adder computes an N-bit sum one bit per clock, LSB first. The adder is built from the team's _xor2, _and2 and _or2 primitives and is instantiated exactly once inside this block. The controller owns the operand and result shift registers, the carry flop, the bit counter and a start/done/ack handshake. It is the area-minimal alternative to a ripple-carry adder: one full-adder instance is reused across WIDTH cycles.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
start  input  1  request a new addition; a, b and cin are sampled on the same edge
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry into bit 0
busy  output  1  high while in RUN
done  output  1  high while in DONE; s, cout and ovf are valid
s  output  WIDTH  sum
cout  output  1  carry out of the MSB
ovf  output  1  signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Single clock domain; all state updates on the rising edge of clk.
- Reset takes priority over everything, including a mid-operation reset.
  - Reset drives state to IDLE.
  - busy, done, s, cout and ovf all reset to 0; internal registers reset to 0.
- Arithmetic
  - The only add logic is the single full-adder instance: sum = a^b^c, carry = a&b | c&(a^b).
  - No '+' operator is permitted in the datapath.
  - The bit counter uses ordinary RTL and is sized for WIDTH.
- FSM states: IDLE, RUN, DONE.
  - busy = (state==RUN); done = (state==DONE); both are decoded from registered state.
- IDLE
  - start=1: load opA<=a, opB<=b, carry<=cin, cnt<=0, go to RUN.
  - Otherwise stay in IDLE; s, cout and ovf hold their last values.
- RUN, each cycle:
  - The full adder takes opA[0], opB[0] and carry.
  - The sum bit shifts into the result register from the MSB end (res <= {sum, res[WIDTH-1:1]}).
  - opA and opB shift right by one; carry <= full-adder carry; cnt increments.
  - On the cycle where cnt==WIDTH-1:
    - capture the pre-update carry as cmsb (carry into the MSB);
    - cout <= full-adder carry, ovf <= cmsb ^ full-adder carry;
    - go to DONE.
  - start is ignored while in RUN.
- Validity of s
  - s is driven from the result register.
  - Its value during RUN is unspecified; the bench checks s only when done=1.
- DONE
  - done=1; s, cout and ovf are held stable.
  - start=1: reload operands and go to RUN, as from IDLE. This is an implicit acknowledge, and done drops on the next cycle.
  - start=0: go to IDLE after exactly one DONE cycle.
  - The result stays readable on s, cout and ovf in IDLE until the next operation completes.
- Latency
  - The start-sampling edge is edge 0; done goes high after edge WIDTH (8 for the default).
  - busy is high for exactly WIDTH cycles.
  - Back-to-back operations run every WIDTH+1 cycles.
- Operands are captured at start; a and b may change freely afterwards.

Test Plan:
- Reset release, start=0 for 5 cycles -> busy=0, done=0, s=8'h00, cout=0, ovf=0 throughout.
- a=8'h3C, b=8'h25, cin=0, start for 1 cycle -> busy high for exactly 8 cycles; then done=1 for 1 cycle with s=8'h61, cout=0, ovf=0; state returns to IDLE.
- Carry-out and overflow cases:
  - 8'hFF+8'h01, cin=0 -> s=8'h00, cout=1, ovf=0.
  - 8'h7F+8'h01 -> s=8'h80, cout=0, ovf=1.
  - 8'h80+8'h80 -> s=8'h00, cout=1, ovf=1.
- Carry-in: 8'hFF+8'hFF, cin=1 -> s=8'hFF, cout=1, ovf=0. Change a and b to 8'h00 one cycle after start -> result unchanged.
- start re-pulsed during RUN is ignored (completes with the original result). reset=1 on the 4th RUN cycle -> next cycle busy=0, done=0, s=0. Then 8'h10+8'h20 -> s=8'h30.
- start held high in the DONE cycle with a=8'h01, b=8'h02 -> done lasts 1 cycle, busy rises the next cycle, second done shows s=8'h03. Repeat at WIDTH=4 with 4'hF+4'h1 -> s=4'h0, cout=1, done after 4 edges.
